// File: rtl/convolution_coprocessor_acc.sv
// convolution_coprocessor_acc
// Sums the unsigned product stream of the convolution multiplier into one
// result per output sample (delimited by prod_last_i), with saturation,
// a saturating tap counter and a valid/ready result port.

module convolution_coprocessor_acc #(
   parameter int DATA_WIDTH = 8,
   parameter int GUARD_BITS = 5,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + GUARD_BITS,
   parameter int CNT_WIDTH  = GUARD_BITS + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear_i,
   input  logic [2*DATA_WIDTH-1:0] prod_i,
   input  logic                    prod_valid_i,
   input  logic                    prod_last_i,
   output logic                    prod_ready_o,
   output logic [ACC_WIDTH-1:0]    sum_o,
   output logic [CNT_WIDTH-1:0]    cnt_o,
   output logic                    ovf_o,
   output logic                    sum_valid_o,
   input  logic                    sum_ready_i,
   output logic                    busy_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [1:0]           state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;

   logic                 in_xfer_s;
   logic [ACC_WIDTH-1:0] base_acc_s;
   logic                 base_ovf_s;
   logic [ACC_WIDTH:0]   sum_ext_s;
   logic [ACC_WIDTH-1:0] sat_acc_s;
   logic                 sat_ovf_s;
   logic [CNT_WIDTH-1:0] cnt_inc_s;

   // Handshake and status decode, all from registered state only
   always_comb begin
      prod_ready_o = (state_q != ST_HOLD);
      sum_valid_o  = (state_q == ST_HOLD);
      busy_o       = (state_q == ST_ACCUM) || (state_q == ST_HOLD);
      sum_o        = acc_q;
      cnt_o        = cnt_q;
      ovf_o        = ovf_q;
      in_xfer_s    = prod_valid_i && (state_q != ST_HOLD);
   end

   // Saturating add: a new sample starts from zero, an ongoing one from acc_q
   always_comb begin
      if (state_q == ST_IDLE) begin
         base_acc_s = {ACC_WIDTH{1'b0}};
         base_ovf_s = 1'b0;
      end else begin
         base_acc_s = acc_q;
         base_ovf_s = ovf_q;
      end
      sum_ext_s = {1'b0, base_acc_s} + {{(GUARD_BITS+1){1'b0}}, prod_i};
      if (base_ovf_s || sum_ext_s[ACC_WIDTH]) begin
         sat_acc_s = ACC_MAX;
         sat_ovf_s = 1'b1;
      end else begin
         sat_acc_s = sum_ext_s[ACC_WIDTH-1:0];
         sat_ovf_s = 1'b0;
      end
      if (state_q == ST_IDLE) begin
         cnt_inc_s = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (cnt_q == CNT_MAX) begin
         cnt_inc_s = CNT_MAX;
      end else begin
         cnt_inc_s = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Next-state logic: accumulate on transfers, hold result, clear aborts everything
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clear_i) begin
         state_d = ST_IDLE;
         acc_d   = {ACC_WIDTH{1'b0}};
         cnt_d   = {CNT_WIDTH{1'b0}};
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (in_xfer_s) begin
                  acc_d   = sat_acc_s;
                  cnt_d   = cnt_inc_s;
                  ovf_d   = sat_ovf_s;
                  state_d = prod_last_i ? ST_HOLD : ST_ACCUM;
               end else begin
                  state_d = state_q;
               end
            end
            ST_HOLD: begin
               if (sum_ready_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d = ST_IDLE;
               acc_d   = {ACC_WIDTH{1'b0}};
               cnt_d   = {CNT_WIDTH{1'b0}};
               ovf_d   = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= {ACC_WIDTH{1'b0}};
         cnt_q   <= {CNT_WIDTH{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_convolution_coprocessor_acc.sv
// Scoreboard bench for convolution_coprocessor_acc: stimulus pushes expected
// {sum,cnt,ovf} results, an independent monitor pops on each output transfer.

module tb_convolution_coprocessor_acc;

   localparam int DW = 8;
   localparam int AW = 21;
   localparam int CW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear_i;
   logic [15:0]   prod_i;
   logic          prod_valid_i;
   logic          prod_last_i;
   logic          prod_ready_o;
   logic [AW-1:0] sum_o;
   logic [CW-1:0] cnt_o;
   logic          ovf_o;
   logic          sum_valid_o;
   logic          sum_ready_i;
   logic          busy_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+CW:0] exp_q[$];

   convolution_coprocessor_acc #(.DATA_WIDTH(DW), .GUARD_BITS(5)) dut (
      .clk(clk), .rst(rst), .clear_i(clear_i), .prod_i(prod_i),
      .prod_valid_i(prod_valid_i), .prod_last_i(prod_last_i),
      .prod_ready_o(prod_ready_o), .sum_o(sum_o), .cnt_o(cnt_o),
      .ovf_o(ovf_o), .sum_valid_o(sum_valid_o), .sum_ready_i(sum_ready_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_res(input int s, input int c, input logic o);
      exp_q.push_back({s[AW-1:0], c[CW-1:0], o});
   endtask

   task automatic send(input logic [15:0] p, input logic l);
      int t;
      t = 0;
      @(negedge clk);
      prod_i = p; prod_valid_i = 1'b1; prod_last_i = l;
      while (!prod_ready_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      prod_valid_i = 1'b0; prod_last_i = 1'b0; prod_i = 16'd0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sum"}, 32'(sum_o), 32'd0);
      chk({tag, "_cnt"}, 32'(cnt_o), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
      chk({tag, "_valid"}, 32'(sum_valid_o), 32'd0);
      chk({tag, "_busy"}, 32'(busy_o), 32'd0);
      chk({tag, "_ready"}, 32'(prod_ready_o), 32'd1);
   endtask

   // Monitor: checks each result transfer against the scoreboard queue
   initial begin
      logic [AW+CW:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (sum_valid_o && sum_ready_i && !rst && !clear_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("res_sum", 32'(sum_o), 32'(e[AW+CW:CW+1]));
               chk("res_cnt", 32'(cnt_o), 32'(e[CW:1]));
               chk("res_ovf", 32'(ovf_o), 32'(e[0]));
            end
         end
      end
   end

   initial begin
      int t;
      rst = 1'b1; clear_i = 1'b0; prod_i = 16'd0; prod_valid_i = 1'b0;
      prod_last_i = 1'b0; sum_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // T1: 10+20+30
      expect_res(60, 3, 1'b0);
      send(16'd10, 1'b0); send(16'd20, 1'b0); send(16'd30, 1'b1);
      @(negedge clk);
      chk("t1_valid", 32'(sum_valid_o), 32'd1);
      chk("t1_ready_low", 32'(prod_ready_o), 32'd0);
      @(negedge clk);
      chk("t1_valid_drop", 32'(sum_valid_o), 32'd0);
      chk("t1_ready_back", 32'(prod_ready_o), 32'd1);

      // T2: single tap held by back-pressure
      sum_ready_i = 1'b0;
      expect_res(65025, 1, 1'b0);
      send(16'd65025, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_valid_hold", 32'(sum_valid_o), 32'd1);
         chk("t2_sum_hold", 32'(sum_o), 32'd65025);
         chk("t2_ready_low", 32'(prod_ready_o), 32'd0);
      end
      @(negedge clk);
      sum_ready_i = 1'b1;
      @(negedge clk);
      chk("t2_idle_valid", 32'(sum_valid_o), 32'd0);
      chk("t2_idle_busy", 32'(busy_o), 32'd0);

      // T3: 32 taps exactly fit, 33 taps saturate
      expect_res(2080800, 32, 1'b0);
      for (int i = 0; i < 32; i++) send(16'd65025, (i == 31));
      expect_res(2097151, 33, 1'b1);
      for (int i = 0; i < 33; i++) send(16'd65025, (i == 32));

      // T4: gaps and a stray last pulse without valid
      expect_res(12, 2, 1'b0);
      send(16'd5, 1'b0);
      @(negedge clk);
      prod_last_i = 1'b1;
      @(negedge clk);
      prod_last_i = 1'b0;
      chk("t4_gap_busy", 32'(busy_o), 32'd1);
      chk("t4_gap_valid", 32'(sum_valid_o), 32'd0);
      @(negedge clk);
      send(16'd7, 1'b1);

      // T5: clear after 2 of 4 taps, product in clear cycle dropped
      send(16'd100, 1'b0); send(16'd200, 1'b0);
      @(negedge clk);
      clear_i = 1'b1; prod_i = 16'd9; prod_valid_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0; prod_valid_i = 1'b0;
      chk("t5_clear_busy", 32'(busy_o), 32'd0);
      chk("t5_clear_cnt", 32'(cnt_o), 32'd0);
      expect_res(3, 2, 1'b0);
      send(16'd1, 1'b0); send(16'd2, 1'b1);

      // T6: async reset mid-ACCUM, then during HOLD
      send(16'd3, 1'b0); send(16'd4, 1'b0);
      @(negedge clk);
      #3 rst = 1'b1;
      #1 chk_reset_outputs("t6_accum");
      @(negedge clk);
      rst = 1'b0;
      sum_ready_i = 1'b0;
      send(16'd8, 1'b1);
      @(negedge clk);
      #3 rst = 1'b1;
      #1 chk_reset_outputs("t6_hold");
      @(negedge clk);
      rst = 1'b0;
      sum_ready_i = 1'b1;
      expect_res(5, 2, 1'b0);
      send(16'd2, 1'b0); send(16'd3, 1'b1);

      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
